udp_tx_framer: RTL
==================

# udp_tx_framer

Builds complete Ethernet/IPv4/UDP frames (without preamble or FCS) from a raw payload byte stream and writes them into the MII MAC transmit FIFO interface. It sits directly upstream of the MAC in the `tx_clk` domain, between the sample packetiser and the MAC. It inserts a fixed 42-byte header with a computed IPv4 header checksum, then the payload, then zero padding up to the 60-byte minimum frame.

## Interface
- `SRC_MAC`, 48'h02_00_00_00_00_01: source MAC address.
- `DST_MAC`, 48'hFF_FF_FF_FF_FF_FF: destination MAC address.
- `SRC_IP`, 32'hC0A8010A: source IPv4 address.
- `DST_IP`, 32'hC0A80101: destination IPv4 address.
- `SRC_PORT`, 16'd5000 / `DST_PORT`, 16'd5001: UDP ports.
- `TTL`, 8'd64: IPv4 time to live.
- `MAX_PAYLOAD`, 1472: largest legal `req_len`.
- `tx_clk`, in, 1: block clock, same as the MAC write clock.
- `rst`, in, 1: reset, synchronous, active-high; clock `tx_clk`.
- `req_valid` / `req_ready`, in/out, 1: packet request handshake.
- `req_len`, in, 11: payload length in bytes.
- `pl_data`, in, 8: payload byte.
- `pl_valid` / `pl_ready`, in/out, 1: payload handshake.
- `mac_data`, out, 8: frame byte to the MAC.
- `mac_sop` / `mac_eop`, out, 1: first and last byte of the frame.
- `mac_err`, out, 1: tied 0.
- `mac_wren`, out, 1: byte write strobe.
- `mac_rdy`, in, 1: MAC can accept a byte this cycle.
- `busy`, out, 1: state is not IDLE.
- `drop_count`, out, 8: number of rejected requests; saturates at 255.

## Operation
- States: IDLE, CSUM0, CSUM1, HDR, PAYLOAD, PAD.
- **IDLE.** `req_ready`=1. When `req_valid` is high, latch `len = req_len`.
  - If `len` is 0 or greater than `MAX_PAYLOAD`: drop the request, increment `drop_count`, stay in IDLE.
  - Otherwise go to CSUM0.
- **CSUM0.** 32-bit sum of the header words: 0x4500, `len+28`, `ident`, 0x4000, {`TTL`,0x11}, and the four IP halfwords.
- **CSUM1.** Fold the carry twice, invert, store as `csum`, go to HDR with `idx`=0.
- **HDR.** Emit header byte `idx` (0..41), big-endian:
  - bytes 0-5: `DST_MAC`
  - bytes 6-11: `SRC_MAC`
  - bytes 12-13: 0x0800
  - byte 14: 0x45
  - byte 15: 0x00
  - bytes 16-17: `len+28`
  - bytes 18-19: `ident`
  - bytes 20-21: 0x4000
  - byte 22: `TTL`
  - byte 23: 0x11
  - bytes 24-25: `csum`
  - bytes 26-29: `SRC_IP`
  - bytes 30-33: `DST_IP`
  - bytes 34-35: `SRC_PORT`
  - bytes 36-37: `DST_PORT`
  - bytes 38-39: `len+8`
  - bytes 40-41: 0x0000 (UDP checksum disabled)
  - After byte 41 is written, go to PAYLOAD.
- **PAYLOAD.** Pass `pl_data` through. After `len` bytes are written:
  - if `42+len` < 60, go to PAD;
  - otherwise go to IDLE.
- **PAD.** Emit 0x00 until 60 bytes have been written in total, then go to IDLE.
- **Packet identification.** `ident` is 16 bits, increments once per completed frame, and wraps from 0xFFFF to 0.
- **Frame flags.**
  - `mac_sop` is high on byte 0.
  - `mac_eop` is high on the last byte: the last payload byte, or the last pad byte when padding.
- **Write rules.**
  - HDR/PAD: `mac_wren = mac_rdy`.
  - PAYLOAD: `mac_wren = pl_valid & mac_rdy`, and `pl_ready = mac_rdy`.
  - All other states: `mac_wren`=0 and `pl_ready`=0.
  - The byte counter advances only on `mac_wren`.
- **Stalls.** When `mac_rdy` or `pl_valid` is low mid-frame, the block holds its state and byte counter and writes nothing.
- **Reset.** `rst` mid-frame returns the block to IDLE and clears `ident` and `drop_count`. The MAC shares `rst`, so it flushes the partial frame.

## Timing
- Reset values: `mac_wren`, `mac_sop`, `mac_eop`, `pl_ready`, `busy`, and `drop_count` are all 0; `req_ready`=1; `mac_data`=0.
- `mac_data`, `mac_sop`, `mac_eop`, `mac_wren` and `pl_ready` are combinational from state, counter, `mac_rdy` and `pl_data`. There is zero added latency on the payload path.
- Request accept to first `mac_wren`: 3 cycles (CSUM0, CSUM1, then HDR byte 0), provided `mac_rdy` is held high.
- With no stalls, a frame takes `max(42+len,60)` cycles of HDR/PAYLOAD/PAD.
- `req_ready` drops the cycle after acceptance and returns in the cycle after `mac_eop` is written.

## Structure
- Package `udp_tx_pkg` holds:
  - the state enum;
  - `HDR_LEN`=42 and `MIN_FRAME`=60;
  - the ethertype (0x0800), IP protocol (0x11) and flags (0x4000);
  - the header byte offsets.
- Sub-module `ipv4_csum` performs the two-cycle sum, fold and invert, with a start/done handshake.

## Test plan
- **Nominal frame.** Default parameters, `len`=100 with payload 0..99 and `mac_rdy`=1 → 142 bytes are written:
  - bytes 16-17 = 0x0080;
  - bytes 24-25 = 0xB711;
  - bytes 38-39 = 0x006C;
  - `mac_eop` on byte 141.
- **Padding.** `len`=1 → 60 bytes are written; byte 42 = payload; bytes 43-59 = 0x00; `mac_eop` on byte 59.
- **Illegal lengths.** `len`=0, then `len`=1473 → no `mac_wren` at all; `drop_count`=2.
- **Backpressure and stalls.** `mac_rdy` toggles randomly and `pl_valid` has gaps → the byte sequence is identical to the unstalled run, with no duplicated or skipped bytes.
- **Back-to-back and wrap.** Three back-to-back requests → `ident` reads 0, 1, 2. After forcing `ident`=0xFFFF, the next frame carries 0xFFFF and the following one carries 0x0000.
- **Reset mid-frame.** Assert `rst` at payload byte 10 → all outputs take their reset values in the next cycle. A fresh request then produces a correct frame with `ident`=0.

Source files
------------

// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP transmit framer.
// Header offsets are byte positions within the 42-byte Ethernet/IPv4/UDP header.
package udp_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CSUM0,
    CSUM1,
    HDR,
    PAYLOAD,
    PAD
  } state_t;

  localparam logic [10:0] HDR_LEN   = 11'd42;
  localparam logic [10:0] MIN_FRAME = 11'd60;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL     = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;

  localparam logic [10:0] OFF_DST_MAC   = 11'd0;
  localparam logic [10:0] OFF_SRC_MAC   = 11'd6;
  localparam logic [10:0] OFF_ETHERTYPE = 11'd12;
  localparam logic [10:0] OFF_VER_IHL   = 11'd14;
  localparam logic [10:0] OFF_TOS       = 11'd15;
  localparam logic [10:0] OFF_TOT_LEN   = 11'd16;
  localparam logic [10:0] OFF_IDENT     = 11'd18;
  localparam logic [10:0] OFF_FLAGS     = 11'd20;
  localparam logic [10:0] OFF_TTL       = 11'd22;
  localparam logic [10:0] OFF_PROTO     = 11'd23;
  localparam logic [10:0] OFF_CSUM      = 11'd24;
  localparam logic [10:0] OFF_SRC_IP    = 11'd26;
  localparam logic [10:0] OFF_DST_IP    = 11'd30;
  localparam logic [10:0] OFF_SRC_PORT  = 11'd34;
  localparam logic [10:0] OFF_DST_PORT  = 11'd36;
  localparam logic [10:0] OFF_UDP_LEN   = 11'd38;
  localparam logic [10:0] OFF_UDP_CSUM  = 11'd40;

  // Byte 'pos' of a big-endian field 'width' bytes wide, right-aligned in 'value'.
  function automatic logic [7:0] be_byte(input logic [47:0] value,
                                         input logic [10:0] width,
                                         input logic [10:0] pos);
    logic [10:0] rev;
    logic [47:0] shifted;
    rev     = width - pos - 11'd1;
    shifted = value >> {rev, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/ipv4_csum.sv
// Two-cycle IPv4 header checksum: sum the header halfwords, then fold and invert.
// done is high in the fold cycle; csum holds the result from the following cycle on.
module ipv4_csum
  import udp_tx_pkg::*;
#(
  parameter logic [7:0]  TTL    = 8'd64,
  parameter logic [31:0] SRC_IP = 32'hC0A8010A,
  parameter logic [31:0] DST_IP = 32'hC0A80101
) (
  input  logic        tx_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] tot_len,
  input  logic [15:0] ident,
  output logic        done,
  output logic [15:0] csum
);

  logic [31:0] sum_q;
  logic        phase_q;
  logic [31:0] word_sum;
  logic [16:0] fold1;
  logic [15:0] fold2;

  assign word_sum = {16'h0, IP_VER_IHL, 8'h00} + {16'h0, tot_len} + {16'h0, ident}
                  + {16'h0, IP_FLAGS_DF} + {16'h0, TTL, IP_PROTO_UDP}
                  + {16'h0, SRC_IP[31:16]} + {16'h0, SRC_IP[15:0]}
                  + {16'h0, DST_IP[31:16]} + {16'h0, DST_IP[15:0]};

  // Second fold cannot carry out: a carry from the first leaves at most 0xFFFE below it.
  assign fold1 = {1'b0, sum_q[15:0]} + {1'b0, sum_q[31:16]};
  assign fold2 = fold1[15:0] + {15'h0, fold1[16]};

  always_ff @(posedge tx_clk) begin
    if (rst) begin
      sum_q   <= '0;
      phase_q <= 1'b0;
      csum    <= '0;
    end else begin
      phase_q <= start;
      if (start)
        sum_q <= word_sum;
      if (phase_q)
        csum <= ~fold2;
    end
  end

  assign done = phase_q;

endmodule

// File: rtl/udp_tx_framer.sv
// Ethernet/IPv4/UDP frame builder feeding the MII MAC transmit FIFO.
// Emits a 42-byte header, passes the payload through unregistered, then pads to 60 bytes.
module udp_tx_framer
  import udp_tx_pkg::*;
#(
  parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
  parameter logic [47:0] DST_MAC     = 48'hFF_FF_FF_FF_FF_FF,
  parameter logic [31:0] SRC_IP      = 32'hC0A8010A,
  parameter logic [31:0] DST_IP      = 32'hC0A80101,
  parameter logic [15:0] SRC_PORT    = 16'd5000,
  parameter logic [15:0] DST_PORT    = 16'd5001,
  parameter logic [7:0]  TTL         = 8'd64,
  parameter logic [10:0] MAX_PAYLOAD = 11'd1472
) (
  input  logic        tx_clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [10:0] req_len,
  input  logic [7:0]  pl_data,
  input  logic        pl_valid,
  output logic        pl_ready,
  output logic [7:0]  mac_data,
  output logic        mac_sop,
  output logic        mac_eop,
  output logic        mac_err,
  output logic        mac_wren,
  input  logic        mac_rdy,
  output logic        busy,
  output logic [7:0]  drop_count
);

  state_t      state, next_state;
  logic [10:0] len_q;
  logic [10:0] cnt;
  logic [15:0] ident;
  logic [7:0]  drop_q;

  logic        req_bad;
  logic [15:0] tot_len;
  logic [15:0] udp_len;
  logic [10:0] pl_end;
  logic        needs_pad;
  logic        hdr_last, pl_last, pad_last;
  logic        csum_done;
  logic [15:0] csum;

  logic [47:0] fld;
  logic [10:0] fld_width;
  logic [10:0] fld_off;
  logic [7:0]  hdr_byte;

  assign req_bad   = (req_len == 11'd0) || (req_len > MAX_PAYLOAD);
  assign tot_len   = {5'b0, len_q} + 16'd28;
  assign udp_len   = {5'b0, len_q} + 16'd8;
  assign pl_end    = HDR_LEN + len_q - 11'd1;
  assign needs_pad = (HDR_LEN + len_q) < MIN_FRAME;
  assign hdr_last  = (cnt == HDR_LEN - 11'd1);
  assign pl_last   = (cnt == pl_end);
  assign pad_last  = (cnt == MIN_FRAME - 11'd1);

  ipv4_csum #(
    .TTL    (TTL),
    .SRC_IP (SRC_IP),
    .DST_IP (DST_IP)
  ) u_csum (
    .tx_clk  (tx_clk),
    .rst     (rst),
    .start   (state == CSUM0),
    .tot_len (tot_len),
    .ident   (ident),
    .done    (csum_done),
    .csum    (csum)
  );

  always_ff @(posedge tx_clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req_valid && !req_bad) next_state = CSUM0;
      CSUM0:   next_state = CSUM1;
      CSUM1:   if (csum_done) next_state = HDR;
      HDR:     if (mac_wren && hdr_last) next_state = PAYLOAD;
      PAYLOAD: if (mac_wren && pl_last) next_state = needs_pad ? PAD : IDLE;
      PAD:     if (mac_wren && pad_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    mac_wren  = 1'b0;
    pl_ready  = 1'b0;
    mac_sop   = 1'b0;
    mac_eop   = 1'b0;
    mac_data  = 8'h00;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      HDR: begin
        mac_wren = mac_rdy;
        mac_sop  = (cnt == 11'd0);
        mac_data = hdr_byte;
      end
      PAYLOAD: begin
        mac_wren = pl_valid & mac_rdy;
        pl_ready = mac_rdy;
        mac_eop  = pl_last && !needs_pad;
        mac_data = pl_data;
      end
      PAD: begin
        mac_wren = mac_rdy;
        mac_eop  = pad_last;
      end
      default: ;
    endcase
  end

  // Pick the header field covering the current byte; be_byte extracts its big-endian byte.
  always_comb begin
    fld       = '0;
    fld_width = 11'd2;
    fld_off   = OFF_UDP_CSUM;
    if (cnt < OFF_SRC_MAC) begin
      fld = DST_MAC;                          fld_width = 11'd6; fld_off = OFF_DST_MAC;
    end else if (cnt < OFF_ETHERTYPE) begin
      fld = SRC_MAC;                          fld_width = 11'd6; fld_off = OFF_SRC_MAC;
    end else if (cnt < OFF_VER_IHL) begin
      fld = {32'h0, ETHERTYPE_IPV4};          fld_width = 11'd2; fld_off = OFF_ETHERTYPE;
    end else if (cnt < OFF_TOS) begin
      fld = {40'h0, IP_VER_IHL};              fld_width = 11'd1; fld_off = OFF_VER_IHL;
    end else if (cnt < OFF_TOT_LEN) begin
      fld = '0;                               fld_width = 11'd1; fld_off = OFF_TOS;
    end else if (cnt < OFF_IDENT) begin
      fld = {32'h0, tot_len};                 fld_width = 11'd2; fld_off = OFF_TOT_LEN;
    end else if (cnt < OFF_FLAGS) begin
      fld = {32'h0, ident};                   fld_width = 11'd2; fld_off = OFF_IDENT;
    end else if (cnt < OFF_TTL) begin
      fld = {32'h0, IP_FLAGS_DF};             fld_width = 11'd2; fld_off = OFF_FLAGS;
    end else if (cnt < OFF_PROTO) begin
      fld = {40'h0, TTL};                     fld_width = 11'd1; fld_off = OFF_TTL;
    end else if (cnt < OFF_CSUM) begin
      fld = {40'h0, IP_PROTO_UDP};            fld_width = 11'd1; fld_off = OFF_PROTO;
    end else if (cnt < OFF_SRC_IP) begin
      fld = {32'h0, csum};                    fld_width = 11'd2; fld_off = OFF_CSUM;
    end else if (cnt < OFF_DST_IP) begin
      fld = {16'h0, SRC_IP};                  fld_width = 11'd4; fld_off = OFF_SRC_IP;
    end else if (cnt < OFF_SRC_PORT) begin
      fld = {16'h0, DST_IP};                  fld_width = 11'd4; fld_off = OFF_DST_IP;
    end else if (cnt < OFF_DST_PORT) begin
      fld = {32'h0, SRC_PORT};                fld_width = 11'd2; fld_off = OFF_SRC_PORT;
    end else if (cnt < OFF_UDP_LEN) begin
      fld = {32'h0, DST_PORT};                fld_width = 11'd2; fld_off = OFF_DST_PORT;
    end else if (cnt < OFF_UDP_CSUM) begin
      fld = {32'h0, udp_len};                 fld_width = 11'd2; fld_off = OFF_UDP_LEN;
    end
    hdr_byte = be_byte(fld, fld_width, cnt - fld_off);
  end

  // The byte counter spans the whole frame; ident advances once the last byte is taken.
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      len_q  <= '0;
      cnt    <= '0;
      ident  <= '0;
      drop_q <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        len_q <= req_len;
        if (req_bad && drop_q != 8'hFF)
          drop_q <= drop_q + 8'd1;
      end
      if (state == CSUM1)
        cnt <= '0;
      else if (mac_wren)
        cnt <= cnt + 11'd1;
      if (mac_wren && mac_eop)
        ident <= ident + 16'd1;
    end
  end

  assign drop_count = drop_q;
  assign mac_err    = 1'b0;

endmodule
